ped_cmd_feeder: RTL and testbench

PED_CMD_FEEDER -- requirements
Module: ped_cmd_feeder

---
 rtl/ped_cmd_feeder_pkg.sv | 30 +++
 rtl/ped_sample_fifo.sv | 68 ++++++
 rtl/ped_cmd_feeder.sv | 216 +++++++++++++++++++++
 tb/tb_ped_cmd_feeder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ped_cmd_feeder_pkg.sv
// ============================================================================
// ped_cmd_feeder_pkg : opcode/state encodings and default sizing for the feeder
// Revision: 1.0
// ============================================================================
`default_nettype none

package ped_cmd_feeder_pkg;

    localparam int c_DEF_DEPTH     = 4;
    localparam int c_DEF_ISSUE_GAP = 4;

    typedef enum logic [1:0] {
        OP_SAMPLE  = 2'b00,
        OP_WEIGHT  = 2'b01,
        OP_DUAL    = 2'b10,
        OP_ILLEGAL = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GET_A      = 3'd1,
        ST_GET_B      = 3'd2,
        ST_GET_D1     = 3'd3,
        ST_GET_D2     = 3'd4,
        ST_WAIT_DRAIN = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ped_sample_fifo.sv
// ============================================================================
// ped_sample_fifo : power-of-two circular FIFO with occupancy, head read is combinational
// Revision: 1.0
// ============================================================================
`default_nettype none

module ped_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_LW = c_PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_level == c_LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ped_cmd_feeder.sv
// ============================================================================
// ped_cmd_feeder : parses a command byte stream into rate-limited step/weight pulses
// Revision: 1.0
// ============================================================================
`default_nettype none

module ped_cmd_feeder
    import ped_cmd_feeder_pkg::*;
#(
    parameter int DEPTH     = c_DEF_DEPTH,
    parameter int ISSUE_GAP = c_DEF_ISSUE_GAP
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   clr_err,
    output logic                   countSteps,
    output logic                   updateWeight,
    output logic                   dualUpdateWeights,
    output logic [7:0]             A,
    output logic [7:0]             B,
    output logic [2:0]             Addr1,
    output logic [2:0]             Addr2,
    output logic [7:0]             Data1,
    output logic [7:0]             Data2,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   err_illegal
);

    localparam int         c_LW  = $clog2(DEPTH) + 1;
    localparam logic [3:0] c_GAP = 4'(ISSUE_GAP);

    state_e          r_state;
    state_e          w_state_nxt;
    opcode_e         w_op;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_push;
    logic            w_err_set;
    logic            w_gap_ok;
    logic            w_smp_issue;
    logic            w_wt_issue;
    logic [3:0]      r_gap;

    logic            r_is_dual;
    logic [2:0]      r_pa1;
    logic [2:0]      r_pa2;
    logic [7:0]      r_pa;
    logic [7:0]      r_pd1;
    logic [7:0]      r_pd2;

    logic [15:0]     w_fifo_rdata;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [c_LW-1:0] w_fifo_level;

    logic            r_cs;
    logic            r_uw;
    logic            r_duw;
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic [2:0]      r_addr1;
    logic [2:0]      r_addr2;
    logic [7:0]      r_data1;
    logic [7:0]      r_data2;
    logic            r_err;

    assign w_op     = opcode_e'(in_data[7:6]);
    assign w_gap_ok = (r_gap >= c_GAP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_SAMPLE:         w_state_nxt = ST_GET_A;
                        OP_WEIGHT, OP_DUAL: w_state_nxt = ST_GET_D1;
                        default:           w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_GET_A:      if (w_accept) w_state_nxt = ST_GET_B;
            ST_GET_B:      if (w_accept) w_state_nxt = ST_IDLE;
            ST_GET_D1:     if (w_accept) w_state_nxt = r_is_dual ? ST_GET_D2 : ST_WAIT_DRAIN;
            ST_GET_D2:     if (w_accept) w_state_nxt = ST_WAIT_DRAIN;
            ST_WAIT_DRAIN: if (w_wt_issue) w_state_nxt = ST_IDLE;
            default:       w_state_nxt = ST_IDLE;
        endcase
    end

    // Samples keep draining while a weight command waits; the weight issues
    // only once the FIFO is empty, which preserves stream order.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            ST_IDLE, ST_GET_A, ST_GET_D1, ST_GET_D2: w_in_ready = 1'b1;
            ST_GET_B:                                w_in_ready = !w_fifo_full;
            default:                                 w_in_ready = 1'b0;
        endcase
        if (!reset) begin
            w_in_ready = 1'b0;
        end
        w_accept    = in_valid && w_in_ready;
        w_push      = w_accept && (r_state == ST_GET_B);
        w_err_set   = w_accept && (r_state == ST_IDLE) && (w_op == OP_ILLEGAL);
        w_wt_issue  = reset && (r_state == ST_WAIT_DRAIN) && w_fifo_empty && w_gap_ok;
        w_smp_issue = reset && !w_fifo_empty && w_gap_ok;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_is_dual <= 1'b0;
            r_pa1     <= '0;
            r_pa2     <= '0;
            r_pa      <= '0;
            r_pd1     <= '0;
            r_pd2     <= '0;
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    r_is_dual <= (w_op == OP_DUAL);
                    r_pa1     <= in_data[2:0];
                    r_pa2     <= in_data[5:3];
                end
                ST_GET_A:  r_pa  <= in_data;
                ST_GET_D1: r_pd1 <= in_data;
                ST_GET_D2: r_pd2 <= in_data;
                default:   ;
            endcase
        end
    end

    ped_sample_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata ({r_pa, in_data}),
        .i_pop   (w_smp_issue),
        .o_rdata (w_fifo_rdata),
        .o_level (w_fifo_level),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cs    <= 1'b0;
            r_uw    <= 1'b0;
            r_duw   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_data1 <= '0;
            r_data2 <= '0;
            r_err   <= 1'b0;
            r_gap   <= c_GAP;
        end else begin
            r_cs  <= w_smp_issue;
            r_uw  <= w_wt_issue && !r_is_dual;
            r_duw <= w_wt_issue && r_is_dual;
            if (w_smp_issue) begin
                {r_a, r_b} <= w_fifo_rdata;
            end
            if (w_wt_issue) begin
                r_addr1 <= r_pa1;
                r_data1 <= r_pd1;
                if (r_is_dual) begin
                    r_addr2 <= r_pa2;
                    r_data2 <= r_pd2;
                end
            end
            // Counter reads 1 in the cycle after a pulse and saturates at the gap.
            if (w_smp_issue || w_wt_issue) begin
                r_gap <= 4'd1;
            end else if (!w_gap_ok) begin
                r_gap <= r_gap + 4'd1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign in_ready          = w_in_ready;
    assign countSteps        = r_cs;
    assign updateWeight      = r_uw;
    assign dualUpdateWeights = r_duw;
    assign A                 = r_a;
    assign B                 = r_b;
    assign Addr1             = r_addr1;
    assign Addr2             = r_addr2;
    assign Data1             = r_data1;
    assign Data2             = r_data2;
    assign fifo_level        = w_fifo_level;
    assign err_illegal       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ped_cmd_feeder.sv
// ============================================================================
// tb_ped_cmd_feeder : directed self-checking bench for ped_cmd_feeder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ped_cmd_feeder;

    localparam int DEPTH = 4;
    localparam int GAP   = 4;

    logic                   clk      = 1'b0;
    logic                   reset    = 1'b0;
    logic [7:0]             in_data  = '0;
    logic                   in_valid = 1'b0;
    logic                   clr_err  = 1'b0;
    logic                   in_ready;
    logic                   countSteps;
    logic                   updateWeight;
    logic                   dualUpdateWeights;
    logic [7:0]             A;
    logic [7:0]             B;
    logic [2:0]             Addr1;
    logic [2:0]             Addr2;
    logic [7:0]             Data1;
    logic [7:0]             Data2;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   err_illegal;

    ped_cmd_feeder #(
        .DEPTH     (DEPTH),
        .ISSUE_GAP (GAP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .clr_err           (clr_err),
        .countSteps        (countSteps),
        .updateWeight      (updateWeight),
        .dualUpdateWeights (dualUpdateWeights),
        .A                 (A),
        .B                 (B),
        .Addr1             (Addr1),
        .Addr2             (Addr2),
        .Data1             (Data1),
        .Data2             (Data2),
        .fifo_level        (fifo_level),
        .err_illegal       (err_illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] a, b, d1, d2;
        logic [2:0] a1, a2;
    } ev_t;

    ev_t evq[$];
    int  n_chk         = 0;
    int  n_fail        = 0;
    int  excl_viol     = 0;
    int  stall_cnt     = 0;
    int  stall_notfull = 0;
    int  last_acc      = 0;
    int  t_ref         = 0;

    // Pulse log: cycle index of the edge that raised each pulse plus the held fields.
    always @(negedge clk) begin
        ev_t e;
        e.cyc = cyc; e.a = A; e.b = B; e.a1 = Addr1; e.a2 = Addr2;
        e.d1 = Data1; e.d2 = Data2; e.kind = 0;
        if (int'(countSteps) + int'(updateWeight) + int'(dualUpdateWeights) > 1) excl_viol++;
        if (countSteps)        begin e.kind = 1; evq.push_back(e); end
        if (updateWeight)      begin e.kind = 2; evq.push_back(e); end
        if (dualUpdateWeights) begin e.kind = 3; evq.push_back(e); end
        if (reset && in_valid && !in_ready) begin
            stall_cnt++;
            if (fifo_level != DEPTH) stall_notfull++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int guard = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            tick(1);
            guard++;
        end
        if (guard >= 200) check_eq("send_timeout", 32'(in_ready), 1);
        tick(1);
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_evt(input int n, input int maxc);
        int k = 0;
        while (evq.size() < n && k < maxc) begin
            tick(1);
            k++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit, expected $finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(2);
        check_eq("rst_in_ready", 32'(in_ready), 0);
        check_eq("rst_level", 32'(fifo_level), 0);
        check_eq("rst_pulses", {countSteps, updateWeight, dualUpdateWeights}, 0);
        check_eq("rst_ab", {A, B}, 0);
        check_eq("rst_wt", {Addr1, Addr2, Data1, Data2}, 0);
        check_eq("rst_err", 32'(err_illegal), 0);
        reset = 1'b1;
        tick(1);
        check_eq("idle_ready", 32'(in_ready), 1);

        // Single sample: pulse one edge after the B byte
        send(8'h00); send(8'h12); send(8'h34);
        t_ref = last_acc;
        check_eq("s1_level_push", 32'(fifo_level), 1);
        wait_evt(1, 10);
        tick(2);
        check_eq("s1_n_events", evq.size(), 1);
        if (evq.size() >= 1) begin
            check_eq("s1_kind", evq[0].kind, 1);
            check_eq("s1_latency", evq[0].cyc, t_ref + 1);
            check_eq("s1_ab", {evq[0].a, evq[0].b}, 16'h1234);
        end
        check_eq("s1_level_end", 32'(fifo_level), 0);
        check_eq("s1_hold_ab", {A, B}, 16'h1234);

        // Back-to-back sample burst, long enough to fill the FIFO
        evq.delete();
        stall_cnt = 0;
        stall_notfull = 0;
        tick(5);
        for (int i = 0; i < 20; i++) begin
            send(8'h00);
            if (i == 0) begin
                send(8'h40); send(8'h80);
                t_ref = last_acc;
            end else begin
                send(8'(8'h40 + i));
                send(8'(8'h80 + i));
            end
        end
        wait_evt(20, 200);
        tick(8);
        check_eq("s2_n_events", evq.size(), 20);
        if (evq.size() >= 1) check_eq("s2_first_latency", evq[0].cyc, t_ref + 1);
        for (int i = 0; i < evq.size(); i++) begin
            check_eq($sformatf("s2_ev%0d", i), {evq[i].kind[7:0], evq[i].a, evq[i].b},
                     32'h014080 + i * 32'h101);
            if (i > 0) check_eq($sformatf("s2_gap%0d", i), evq[i].cyc - evq[i-1].cyc, GAP);
        end
        check_eq("s2_stall_seen", 32'(stall_cnt > 0), 1);
        check_eq("s2_stall_notfull", stall_notfull, 0);
        check_eq("s2_level_end", 32'(fifo_level), 0);

        // Two samples then a WEIGHT command that must wait for the drain
        evq.delete();
        tick(5);
        send(8'h00); send(8'h01); send(8'h02);
        send(8'h00); send(8'h03); send(8'h04);
        send(8'h45); send(8'hAA);
        t_ref = last_acc;
        check_eq("s3_ready_wait0", 32'(in_ready), 0);
        tick(2);
        check_eq("s3_ready_wait2", 32'(in_ready), 0);
        wait_evt(3, 50);
        tick(3);
        check_eq("s3_n_events", evq.size(), 3);
        if (evq.size() == 3) begin
            check_eq("s3_ev0", {evq[0].kind[7:0], evq[0].a, evq[0].b}, 32'h010102);
            check_eq("s3_ev1", {evq[1].kind[7:0], evq[1].a, evq[1].b}, 32'h010304);
            check_eq("s3_wt_kind", evq[2].kind, 2);
            check_eq("s3_wt_fields", {5'b0, evq[2].a1, evq[2].d1}, 16'h05AA);
            check_eq("s3_wt_gap", evq[2].cyc - evq[1].cyc, 4);
            check_eq("s3_wt_time", evq[2].cyc, t_ref + 4);
        end
        check_eq("s3_hold_ab", {A, B}, 16'h0304);
        check_eq("s3_ready_back", 32'(in_ready), 1);

        // DUAL command, Addr1=2 Addr2=3
        evq.delete();
        tick(6);
        send(8'h9A); send(8'h11); send(8'h22);
        t_ref = last_acc;
        check_eq("s4_ready_wait", 32'(in_ready), 0);
        wait_evt(1, 20);
        tick(6);
        check_eq("s4_n_events", evq.size(), 1);
        if (evq.size() >= 1) begin
            check_eq("s4_kind", evq[0].kind, 3);
            check_eq("s4_time", evq[0].cyc, t_ref + 1);
        end
        check_eq("s4_addr", {Addr1, Addr2}, {3'd2, 3'd3});
        check_eq("s4_data", {Data1, Data2}, 16'h1122);
        check_eq("s4_pulse_low", 32'(dualUpdateWeights), 0);

        // Illegal header, simultaneous set/clear, then a clean packet
        evq.delete();
        send(8'hC0);
        check_eq("s5_err_set", 32'(err_illegal), 1);
        check_eq("s5_idle_ready", 32'(in_ready), 1);
        clr_err = 1'b1;
        send(8'hC0);
        clr_err = 1'b0;
        check_eq("s5_err_setclr", 32'(err_illegal), 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check_eq("s5_err_clr", 32'(err_illegal), 0);
        check_eq("s5_no_pulse", evq.size(), 0);
        send(8'h00); send(8'h55); send(8'h66);
        wait_evt(1, 20);
        tick(2);
        check_eq("s5_after_err", {A, B}, 16'h5566);

        // Reset in GET_B drops the partial packet and clears everything
        tick(5);
        evq.delete();
        send(8'hC0); send(8'h00); send(8'h77);
        reset = 1'b0;
        tick(1);
        check_eq("s6_rst_ready", 32'(in_ready), 0);
        check_eq("s6_rst_level", 32'(fifo_level), 0);
        check_eq("s6_rst_outs", {A, B, Addr1, Addr2, Data1, Data2}, 0);
        check_eq("s6_rst_err", 32'(err_illegal), 0);
        reset = 1'b1;
        tick(6);
        check_eq("s6_no_pulse", evq.size(), 0);
        check_eq("s6_level", 32'(fifo_level), 0);
        check_eq("s6_idle_ready", 32'(in_ready), 1);

        check_eq("one_hot", excl_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
